// File: rtl/lsu_dccm_stbuf_if.sv
// Store-buffer bus bundle: store enqueue, load hit check and DCCM port signals.
// slave = store buffer side, master = core/DCCM side.
interface lsu_dccm_stbuf_if #(
  parameter int unsigned DCCM_BITS  = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  lsu_freeze_dc3;
  logic                  st_valid;
  logic [DCCM_BITS-1:0]  st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [BE_W-1:0]       st_byteen;
  logic                  stbuf_full;
  logic                  stbuf_empty;
  logic                  pipe_rden;
  logic [DCCM_BITS-1:0]  ld_addr;
  logic [BE_W-1:0]       ld_hit_mask;
  logic [DATA_WIDTH-1:0] ld_fwd_data;
  logic                  ld_stall;
  logic                  stbuf_rden;
  logic [DCCM_BITS-1:0]  stbuf_rd_addr;
  logic [DATA_WIDTH-1:0] dccm_rd_data_lo;
  logic                  dccm_wren;
  logic [DCCM_BITS-1:0]  dccm_wr_addr;
  logic [DATA_WIDTH-1:0] dccm_wr_data;

  modport slave (
    input  lsu_freeze_dc3, st_valid, st_addr, st_data, st_byteen,
           pipe_rden, ld_addr, dccm_rd_data_lo,
    output stbuf_full, stbuf_empty, ld_hit_mask, ld_fwd_data, ld_stall,
           stbuf_rden, stbuf_rd_addr, dccm_wren, dccm_wr_addr, dccm_wr_data
  );

  modport master (
    output lsu_freeze_dc3, st_valid, st_addr, st_data, st_byteen,
           pipe_rden, ld_addr, dccm_rd_data_lo,
    input  stbuf_full, stbuf_empty, ld_hit_mask, ld_fwd_data, ld_stall,
           stbuf_rden, stbuf_rd_addr, dccm_wren, dccm_wr_addr, dccm_wr_data
  );
endinterface

// File: rtl/lsu_dccm_stbuf.sv
// Committed-store buffer in front of the DCCM write port; partial words via read-modify-write.
// Optional macro LSU_STBUF_FWD_EN: forward buffered bytes to loads instead of stalling them.
module lsu_dccm_stbuf #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DCCM_BITS  = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_l,
  lsu_dccm_stbuf_if.slave  bus
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned AW   = DCCM_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDWAIT = 2'd1,
    S_WR     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [AW-1:0]         r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [BE_W-1:0]       r_be   [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_merge;

  logic                  w_full;
  logic                  w_head_valid;
  logic                  w_issue;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_wren;
  logic                  w_rden;
  logic                  w_cap;
  logic [AW-1:0]         w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [BE_W-1:0]       w_head_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [PW-1:0]         w_hit_idx;
  logic [BE_W-1:0]       w_hit_mask;
  logic [DATA_WIDTH-1:0] w_fwd;
  logic                  w_unused;

  assign w_head_addr  = r_addr[r_rd_ptr];
  assign w_head_data  = r_data[r_rd_ptr];
  assign w_head_be    = r_be[r_rd_ptr];
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_issue      = w_head_valid & ~bus.pipe_rden & ~bus.lsu_freeze_dc3;
  assign w_enq        = bus.st_valid & ~w_full;

  // Merge head store lanes over the word just read back from the DCCM
  always_comb begin
    w_merged = '0;
    for (int b = 0; b < BE_W; b++) begin
      w_merged[b*8 +: 8] = w_head_be[b] ? w_head_data[b*8 +: 8] : bus.dccm_rd_data_lo[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Drain FSM: full words write directly, partial words go read -> merge -> write
  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    w_wren      = 1'b0;
    w_rden      = 1'b0;
    w_cap       = 1'b0;
    w_wdata     = w_head_data;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (&w_head_be) begin
            w_wren = 1'b1;
            w_deq  = 1'b1;
          end else begin
            w_rden      = 1'b1;
            w_state_nxt = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        w_cap       = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_wdata = r_merge;
        if (w_issue) begin
          w_wren      = 1'b1;
          w_deq       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entry storage, pointers, occupancy and merge register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_merge  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
        r_be[k]   <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_wr_ptr] <= bus.st_addr[DCCM_BITS-1:2];
        r_data[r_wr_ptr] <= bus.st_data;
        r_be[r_wr_ptr]   <= bus.st_byteen;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_cap) r_merge <= w_merged;
    end
  end

  // Load hit check, oldest to youngest so younger stores win each lane
  always_comb begin
    w_hit_mask = '0;
    w_fwd      = '0;
    w_hit_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_hit_idx] == bus.ld_addr[DCCM_BITS-1:2])) begin
        w_hit_mask = w_hit_mask | r_be[w_hit_idx];
        for (int b = 0; b < BE_W; b++) begin
          if (r_be[w_hit_idx][b]) w_fwd[b*8 +: 8] = r_data[w_hit_idx][b*8 +: 8];
        end
      end
    end
  end

  assign bus.ld_hit_mask   = w_hit_mask;
`ifdef LSU_STBUF_FWD_EN
  assign bus.ld_fwd_data   = w_fwd;
  assign bus.ld_stall      = 1'b0;
  assign w_unused          = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
`else
  assign bus.ld_fwd_data   = '0;
  assign bus.ld_stall      = |w_hit_mask;
  assign w_unused          = ^{bus.st_addr[1:0], bus.ld_addr[1:0], w_fwd};
`endif

  assign bus.stbuf_full    = w_full;
  assign bus.stbuf_empty   = (r_count == '0) && (r_state == S_IDLE);
  assign bus.dccm_wren     = w_wren;
  assign bus.dccm_wr_addr  = w_wren ? {w_head_addr, 2'b00} : '0;
  assign bus.dccm_wr_data  = w_wren ? w_wdata : '0;
  assign bus.stbuf_rden    = w_rden;
  assign bus.stbuf_rd_addr = w_rden ? {w_head_addr, 2'b00} : '0;

endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Self-checking bench for lsu_dccm_stbuf: directed scenarios plus randomized traffic
// against a queue-based store-buffer model and a reference memory image.
module tb_lsu_dccm_stbuf;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DCCM_BITS  = 16;
  localparam int unsigned DATA_WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;

  lsu_dccm_stbuf_if #(.DCCM_BITS(DCCM_BITS), .DATA_WIDTH(DATA_WIDTH)) bus ();

  lsu_dccm_stbuf #(.DEPTH(DEPTH), .DCCM_BITS(DCCM_BITS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // DCCM behavioural model: read data appears the cycle after a read request
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.stbuf_rden) bus.dccm_rd_data_lo <= mem[bus.stbuf_rd_addr[15:2]];
    if (bus.dccm_wren)  mem[bus.dccm_wr_addr[15:2]] <= bus.dccm_wr_data;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ref_mem [0:16383];
  logic [13:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [3:0]  q_be   [$];

  function automatic logic [31:0] merge_w(input logic [31:0] nw, input logic [31:0] old,
                                          input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.st_valid       = 1'b0;
    bus.st_addr        = '0;
    bus.st_data        = '0;
    bus.st_byteen      = '0;
    bus.pipe_rden      = 1'b0;
    bus.lsu_freeze_dc3 = 1'b0;
    bus.ld_addr        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic push_st(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_valid  = 1'b1;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_byteen = be;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_l = 1'b0;
    idle_inputs();
    #1;
    n_vec++; if (bus.stbuf_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus.stbuf_empty); end
    n_vec++; if (bus.stbuf_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus.stbuf_full); end
    n_vec++; if ({bus.dccm_wren, bus.stbuf_rden, bus.ld_stall} !== 3'b000) begin n_err++;
      $display("FAIL reset_ctrl got wren/rden/stall=%b exp=000", {bus.dccm_wren, bus.stbuf_rden, bus.ld_stall}); end
    n_vec++; if ({bus.ld_hit_mask, bus.ld_fwd_data, bus.dccm_wr_addr, bus.dccm_wr_data, bus.stbuf_rd_addr} !== '0) begin n_err++;
      $display("FAIL reset_data got nonzero mask/fwd/addr/data exp=0"); end
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_full_word();
    do_reset();
    push_st(16'h0100, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (bus.dccm_wren !== 1'b1) begin n_err++; $display("FAIL fw_wren got=%b exp=1", bus.dccm_wren); end
    n_vec++; if (bus.dccm_wr_addr !== 16'h0100) begin n_err++; $display("FAIL fw_addr got=%h exp=0100", bus.dccm_wr_addr); end
    n_vec++; if (bus.dccm_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL fw_data got=%h exp=deadbeef", bus.dccm_wr_data); end
    n_vec++; if (bus.stbuf_rden !== 1'b0) begin n_err++; $display("FAIL fw_rden got=%b exp=0", bus.stbuf_rden); end
    @(negedge clk);
    #1;
    n_vec++; if (bus.stbuf_empty !== 1'b1 || bus.dccm_wren !== 1'b0) begin n_err++;
      $display("FAIL fw_after got empty=%b wren=%b exp empty=1 wren=0", bus.stbuf_empty, bus.dccm_wren); end
  endtask

  // Full-word preload, then a partial store completed by RMW; optional pipe/freeze hold in WR
  task automatic test_rmw(input logic [15:0] a, input logic [31:0] base, input logic [31:0] d,
                          input logic [3:0] be, input int hold_pipe, input int hold_frz);
    logic [31:0] exp_w;
    exp_w = merge_w(d, base, be);
    do_reset();
    push_st(a, base, 4'hF);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    push_st(a, d, be);
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (bus.stbuf_rden !== 1'b1 || bus.stbuf_rd_addr !== a || bus.dccm_wren !== 1'b0) begin n_err++;
      $display("FAIL rmw_rd got rden=%b addr=%h wren=%b exp rden=1 addr=%h wren=0", bus.stbuf_rden, bus.stbuf_rd_addr, bus.dccm_wren, a); end
    @(negedge clk);
    #1;
    n_vec++; if (bus.stbuf_rden !== 1'b0 || bus.dccm_wren !== 1'b0 || bus.stbuf_empty !== 1'b0) begin n_err++;
      $display("FAIL rmw_wait got rden=%b wren=%b empty=%b exp 0/0/0", bus.stbuf_rden, bus.dccm_wren, bus.stbuf_empty); end
    for (int i = 0; i < hold_pipe + hold_frz; i++) begin
      @(negedge clk);
      bus.pipe_rden      = (i < hold_pipe);
      bus.lsu_freeze_dc3 = (i >= hold_pipe);
      #1;
      n_vec++; if (bus.dccm_wren !== 1'b0 || bus.stbuf_rden !== 1'b0) begin n_err++;
        $display("FAIL rmw_hold cyc=%0d got wren=%b rden=%b exp 0/0", i, bus.dccm_wren, bus.stbuf_rden); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (bus.dccm_wren !== 1'b1 || bus.dccm_wr_addr !== a || bus.dccm_wr_data !== exp_w) begin n_err++;
      $display("FAIL rmw_wr got wren=%b addr=%h data=%h exp 1 %h %h", bus.dccm_wren, bus.dccm_wr_addr, bus.dccm_wr_data, a, exp_w); end
    @(negedge clk);
    #1;
    n_vec++; if (bus.stbuf_empty !== 1'b1) begin n_err++; $display("FAIL rmw_empty got=%b exp=1", bus.stbuf_empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      push_st(16'h0500 + 16'(4 * i), d[i], 4'hF);
      bus.pipe_rden = 1'b1;
      @(negedge clk);
    end
    push_st(16'h0600, 32'h0BADF00D, 4'hF);
    #1;
    n_vec++; if (bus.stbuf_full !== 1'b1) begin n_err++; $display("FAIL b2b_full got=%b exp=1", bus.stbuf_full); end
    @(negedge clk);
    idle_inputs();
    bus.pipe_rden = 1'b1;
    #1;
    n_vec++; if (bus.stbuf_full !== 1'b1 || bus.dccm_wren !== 1'b0) begin n_err++;
      $display("FAIL b2b_drop got full=%b wren=%b exp 1/0", bus.stbuf_full, bus.dccm_wren); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.pipe_rden = 1'b0;
      #1;
      n_vec++; if (bus.dccm_wren !== 1'b1 || bus.dccm_wr_addr !== 16'h0500 + 16'(4 * i) || bus.dccm_wr_data !== d[i]) begin n_err++;
        $display("FAIL b2b_wr%0d got wren=%b addr=%h data=%h exp 1 %h %h", i, bus.dccm_wren, bus.dccm_wr_addr,
                 bus.dccm_wr_data, 16'h0500 + 16'(4 * i), d[i]); end
      n_vec++; if (bus.stbuf_full !== (i == 0)) begin n_err++; $display("FAIL b2b_fullflag%0d got=%b exp=%b", i, bus.stbuf_full, i == 0); end
    end
    @(negedge clk);
    #1;
    n_vec++; if (bus.dccm_wren !== 1'b0 || bus.stbuf_empty !== 1'b1) begin n_err++;
      $display("FAIL b2b_end got wren=%b empty=%b exp 0/1", bus.dccm_wren, bus.stbuf_empty); end
  endtask

  task automatic test_hit();
    int n_wr;
    do_reset();
    bus.pipe_rden = 1'b1;
    push_st(16'h0300, 32'h000000AA, 4'h1);
    @(negedge clk);
    push_st(16'h0300, 32'h000000BB, 4'h1);
    @(negedge clk);
    idle_inputs();
    bus.pipe_rden = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.ld_addr = (j == 2) ? 16'h0304 : 16'h0300 + 16'(2 * j);
      #1;
      n_vec++; if (bus.ld_hit_mask !== ((j == 2) ? 4'h0 : 4'h1)) begin n_err++;
        $display("FAIL hit_mask ld=%h got=%h exp=%h", bus.ld_addr, bus.ld_hit_mask, (j == 2) ? 4'h0 : 4'h1); end
`ifdef LSU_STBUF_FWD_EN
      n_vec++; if (bus.ld_stall !== 1'b0 || bus.ld_fwd_data[7:0] !== ((j == 2) ? 8'h00 : 8'hBB)) begin n_err++;
        $display("FAIL hit_fwd got stall=%b fwd=%h", bus.ld_stall, bus.ld_fwd_data); end
`else
      n_vec++; if (bus.ld_stall !== (j != 2) || bus.ld_fwd_data !== 32'h0) begin n_err++;
        $display("FAIL hit_stall got stall=%b fwd=%h exp stall=%b fwd=0", bus.ld_stall, bus.ld_fwd_data, j != 2); end
`endif
      #1;
    end
    n_wr = 0;
    for (int c = 0; c < 20 && n_wr < 2; c++) begin
      @(negedge clk);
      bus.pipe_rden = 1'b0;
      bus.ld_addr   = 16'h0300;
      #1;
`ifdef LSU_STBUF_FWD_EN
      n_vec++; if (bus.ld_stall !== 1'b0 || bus.ld_fwd_data[7:0] !== 8'hBB) begin n_err++;
        $display("FAIL drain_fwd got stall=%b fwd=%h exp 0 bb", bus.ld_stall, bus.ld_fwd_data[7:0]); end
`else
      n_vec++; if (bus.ld_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall got=%b exp=1", bus.ld_stall); end
`endif
      if (bus.dccm_wren === 1'b1) n_wr++;
    end
    n_vec++; if (n_wr != 2) begin n_err++; $display("FAIL hit_drain_timeout writes=%0d exp=2", n_wr); end
    @(negedge clk);
    #1;
    n_vec++; if (bus.ld_stall !== 1'b0 || bus.ld_hit_mask !== 4'h0 || bus.stbuf_empty !== 1'b1) begin n_err++;
      $display("FAIL hit_after got stall=%b mask=%h empty=%b exp 0 0 1", bus.ld_stall, bus.ld_hit_mask, bus.stbuf_empty); end
  endtask

  task automatic test_reset_rmw();
    do_reset();
    push_st(16'h0700, 32'h00000055, 4'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (bus.stbuf_rden !== 1'b1) begin n_err++; $display("FAIL rst_rmw_rd got=%b exp=1", bus.stbuf_rden); end
    @(negedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    n_vec++; if (bus.stbuf_empty !== 1'b1 || bus.stbuf_full !== 1'b0 || bus.dccm_wren !== 1'b0) begin n_err++;
      $display("FAIL rst_rmw_flags got empty=%b full=%b wren=%b exp 1 0 0", bus.stbuf_empty, bus.stbuf_full, bus.dccm_wren); end
    @(negedge clk);
    rst_l = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_vec++; if (bus.dccm_wren !== 1'b0 || bus.stbuf_rden !== 1'b0 || bus.stbuf_empty !== 1'b1) begin n_err++;
        $display("FAIL rst_rmw_quiet cyc=%0d got wren=%b rden=%b empty=%b", c, bus.dccm_wren, bus.stbuf_rden, bus.stbuf_empty); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  emask;
    logic [31:0] efwd;
    logic [31:0] exp_w;
    logic [13:0] lw;
    logic        full_b;
    do_reset();
    q_addr.delete(); q_data.delete(); q_be.delete();
    for (int c = 0; c < 560; c++) begin
      @(negedge clk);
      if (c < 8) begin
        push_st(16'h0400 + 16'(4 * c), $urandom, 4'hF);
        bus.pipe_rden = 1'b0; bus.lsu_freeze_dc3 = 1'b0;
      end else if (c < 500) begin
        bus.st_valid = ($urandom_range(0, 2) == 0);
        bus.st_addr  = 16'h0400 + 16'(4 * $urandom_range(0, 7)) + 16'($urandom_range(0, 3));
        bus.st_data  = $urandom;
        bus.st_byteen = 4'($urandom_range(1, 15));
        bus.pipe_rden = ($urandom_range(0, 1) == 0);
        bus.lsu_freeze_dc3 = ($urandom_range(0, 6) == 0);
      end else begin
        idle_inputs();
      end
      bus.ld_addr = 16'h0400 + 16'(4 * $urandom_range(0, 7)) + 16'($urandom_range(0, 3));
      #1;
      full_b = (q_addr.size() == DEPTH);
      lw = bus.ld_addr[15:2];
      emask = '0; efwd = '0;
      foreach (q_addr[i]) if (q_addr[i] == lw) begin
        emask |= q_be[i];
        for (int b = 0; b < 4; b++) if (q_be[i][b]) efwd[b*8 +: 8] = q_data[i][b*8 +: 8];
      end
      n_vec++; if (bus.stbuf_full !== full_b || bus.stbuf_empty !== (q_addr.size() == 0)) begin n_err++;
        $display("FAIL rnd_flags c=%0d got full=%b empty=%b exp %b %b", c, bus.stbuf_full, bus.stbuf_empty, full_b, q_addr.size() == 0); end
      n_vec++; if (bus.ld_hit_mask !== emask) begin n_err++;
        $display("FAIL rnd_mask c=%0d got=%h exp=%h", c, bus.ld_hit_mask, emask); end
`ifdef LSU_STBUF_FWD_EN
      n_vec++; if (bus.ld_stall !== 1'b0 || bus.ld_fwd_data !== efwd) begin n_err++;
        $display("FAIL rnd_fwd c=%0d got stall=%b fwd=%h exp 0 %h", c, bus.ld_stall, bus.ld_fwd_data, efwd); end
`else
      n_vec++; if (bus.ld_stall !== (emask != 4'h0) || bus.ld_fwd_data !== 32'h0) begin n_err++;
        $display("FAIL rnd_stall c=%0d got stall=%b fwd=%h exp %b 0", c, bus.ld_stall, bus.ld_fwd_data, emask != 4'h0); end
`endif
      n_vec++; if ((bus.dccm_wren && bus.stbuf_rden) ||
                   ((bus.dccm_wren || bus.stbuf_rden) && (bus.pipe_rden || bus.lsu_freeze_dc3))) begin n_err++;
        $display("FAIL rnd_port c=%0d got wren=%b rden=%b with pipe=%b frz=%b", c, bus.dccm_wren, bus.stbuf_rden,
                 bus.pipe_rden, bus.lsu_freeze_dc3); end
      if (bus.dccm_wren === 1'b1) begin
        if (q_addr.size() == 0) begin
          n_vec++; n_err++; $display("FAIL rnd_spurious_wr c=%0d addr=%h", c, bus.dccm_wr_addr);
        end else begin
          exp_w = merge_w(q_data[0], ref_mem[q_addr[0]], q_be[0]);
          n_vec++; if (bus.dccm_wr_addr !== {q_addr[0], 2'b00} || bus.dccm_wr_data !== exp_w) begin n_err++;
            $display("FAIL rnd_wr c=%0d got addr=%h data=%h exp %h %h", c, bus.dccm_wr_addr, bus.dccm_wr_data,
                     {q_addr[0], 2'b00}, exp_w); end
          ref_mem[q_addr[0]] = exp_w;
          void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_be.pop_front());
        end
      end
      if (bus.st_valid && !full_b) begin
        q_addr.push_back(bus.st_addr[15:2]);
        q_data.push_back(bus.st_data);
        q_be.push_back(bus.st_byteen);
      end
    end
    @(negedge clk);
    #1;
    n_vec++; if (q_addr.size() != 0 || bus.stbuf_empty !== 1'b1) begin n_err++;
      $display("FAIL rnd_drain_timeout left=%0d empty=%b", q_addr.size(), bus.stbuf_empty); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (mem[14'h100 + 14'(i)] !== ref_mem[14'h100 + 14'(i)]) begin n_err++;
        $display("FAIL rnd_mem word=%0d got=%h exp=%h", i, mem[14'h100 + 14'(i)], ref_mem[14'h100 + 14'(i)]); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_full_word();
    test_rmw(16'h0200, 32'h11223344, 32'h0000AA00, 4'h2, 0, 0);
    test_rmw(16'h0204, 32'hA5A5A5A5, 32'h77000088, 4'h9, 3, 2);
    test_back_to_back();
    test_hit();
    test_reset_rmw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/lsu_dccm_stbuf.md
Name: lsu_dccm_stbuf

Overview:
Committed-store buffer sitting directly upstream of the DCCM memory write port. Holds up to DEPTH committed word stores with byte enables and drains them in order into the single-ported DCCM. Drain uses only cycles the load pipe leaves idle. Partial-word stores are completed by read-modify-write through the DCCM lo read port; younger loads are checked against buffered stores.

Parameters:
DEPTH, 4, number of store entries (power of 2, >=2)
DCCM_BITS, 16, DCCM byte-address width
DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
lsu_freeze_dc3  in  1  pipe freeze; no DCCM access issued while high
st_valid  in  1  committed store enqueue request
st_addr  in  DCCM_BITS  store address; bits [1:0] ignored
st_data  in  DATA_WIDTH  store data, byte-lane aligned
st_byteen  in  DATA_WIDTH/8  byte enables; nonzero
stbuf_full  out  1  no free entry; st_valid ignored when high
stbuf_empty  out  1  no valid entries and drain FSM idle
pipe_rden  in  1  load pipe owns the DCCM port this cycle (priority)
ld_addr  in  DCCM_BITS  load address for hit check
ld_hit_mask  out  DATA_WIDTH/8  byte lanes of ld_addr word covered by buffered stores
ld_fwd_data  out  DATA_WIDTH  forwarded bytes (see Optional Feature)
ld_stall  out  1  load must replay
stbuf_rden  out  1  RMW read request to DCCM lo port
stbuf_rd_addr  out  DCCM_BITS  RMW read address, word aligned
dccm_rd_data_lo  in  DATA_WIDTH  DCCM lo read data, valid cycle after read
dccm_wren  out  1  DCCM write enable
dccm_wr_addr  out  DCCM_BITS  write address, word aligned
dccm_wr_data  out  DATA_WIDTH  write data

Behaviour:
- Circular FIFO: wr_ptr, rd_ptr, count (log2(DEPTH)+1 bits); pointers wrap at DEPTH.
- Enqueue when st_valid & ~stbuf_full; entry usable by drain next cycle. st_valid while full is dropped; upstream guarantees it never happens. stbuf_full = (count==DEPTH), registered-count based; dequeue in same cycle does not clear full until next cycle.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Drain FSM states IDLE, RDWAIT, WR. Issue condition: head valid & ~pipe_rden & ~lsu_freeze_dc3.
- IDLE, issue, byteen all ones: dccm_wren=1 with head addr/data same cycle, dequeue, stay IDLE.
- IDLE, issue, partial byteen: stbuf_rden=1, stbuf_rd_addr=head addr, go RDWAIT.
- RDWAIT: capture dccm_rd_data_lo into merge register (unconditional, freeze ignored); merged word = head data in enabled lanes, read data elsewhere; go WR.
- WR: on issue condition, dccm_wren=1 with merge register, dequeue, go IDLE; otherwise hold.
- dccm_wren and stbuf_rden never high together; neither high while pipe_rden or lsu_freeze_dc3.
- Hit check: compare ld_addr[DCCM_BITS-1:2] with every valid entry including head in flight; ld_hit_mask = OR of matching byte enables.
- stbuf_empty = (count==0) & state==IDLE.
- Reset (any time, including mid-RMW): count=0, pointers=0, state=IDLE; all outputs 0 except stbuf_empty=1; buffered stores discarded.

Optional Feature:
Macro LSU_STBUF_FWD_EN. Defined: ld_fwd_data per byte lane from youngest matching entry; ld_stall=0. Undefined: ld_fwd_data=0; ld_stall = |ld_hit_mask; load replays until hitting stores drain.

Test Plan:
- Reset, enqueue addr 0x0100 data 0xDEADBEEF byteen 0xF, pipe idle -> next cycle dccm_wren=1, wr_addr 0x0100, wr_data 0xDEADBEEF; stbuf_empty=1 after.
- DCCM 0x0200 holds 0x11223344; enqueue byte store byteen 0x2 data 0x0000AA00 -> stbuf_rden cycle N, dccm_wren cycle N+2 with 0x1122AA44.
- Enqueue 4 full stores with pipe_rden=1 -> stbuf_full=1, 5th st_valid ignored; drop pipe_rden -> 4 writes on 4 consecutive cycles in order.
- RMW in WR with pipe_rden held 3 cycles -> dccm_wren delayed 3 cycles, data unchanged; freeze likewise blocks.
- Two stores to 0x0300 (0x0000_00AA byteen 0x1, then 0x0000_00BB byteen 0x1), load 0x0300 -> ld_hit_mask=0x1; with FWD_EN ld_fwd_data[7:0]=0xBB, ld_stall=0; without, ld_stall=1 until both drained.
- Assert rst_l low during RDWAIT -> no dccm_wren afterwards, stbuf_empty=1, stbuf_full=0.
